// File: rtl/md5_bf_sched.sv
// md5_bf_sched: scans a BCD decimal range, issuing LANES ASCII candidates per cycle to external MD5 cores and latching the first matching tag.
// Define MD5_BF_PROGRESS_EN to add the saturating progress output (count of issued candidates).
module md5_bf_sched #(
  parameter int LANES = 4,
  parameter int DIGITS = 8,
  parameter int PIPE_LAT = 70
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [4*DIGITS-1:0]         low,
  input  logic [4*DIGITS-1:0]         high,
  input  logic [127:0]                hash,
  output logic [LANES-1:0]            cand_valid,
  output logic [LANES*8*DIGITS-1:0]   cand_msg,
  output logic [LANES*4*DIGITS-1:0]   cand_pass,
  input  logic [LANES-1:0]            res_valid,
  input  logic [LANES*128-1:0]        res_hash,
  input  logic [LANES*4*DIGITS-1:0]   res_pass,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [4*DIGITS-1:0]         pass
`ifdef MD5_BF_PROGRESS_EN
  ,
  output logic [31:0]                 progress
`endif
);
  localparam int W = 4*DIGITS;
  localparam int CW = $clog2(PIPE_LAT+1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [W-1:0] base, high_r, next_base, hit_pass;
  logic [127:0] hash_r;
  logic [CW-1:0] drain_cnt;
  logic [LANES-1:0] lane_ok;
  logic [LANES*W-1:0] lane_val;
  logic exh_c, exhausted, hit, bcd_ok;

  function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input int n);
    logic [4:0] d;
    logic c;
    int m;
    logic [W-1:0] s;
    c = 1'b0;
    m = n;
    s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = {1'b0, a[4*i +: 4]} + 5'(m % 10) + {4'd0, c};
      c = d > 5'd9;
      s[4*i +: 4] = c ? 4'(d - 5'd10) : d[3:0];
      m = m / 10;
    end
    return {c | (m != 0), s};
  endfunction

  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) ok = ok & (v[4*i +: 4] <= 4'd9);
    return ok;
  endfunction

  assign bcd_ok = is_bcd(low) && is_bcd(high);
  assign {exh_c, next_base} = bcd_add(base, LANES);
  assign exhausted = exh_c || next_base > high_r;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [W:0] s;
    assign s = bcd_add(base, k);
    assign lane_val[k*W +: W] = s[W-1:0];
    assign lane_ok[k] = !s[W] && s[W-1:0] <= high_r;
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      assign cand_msg[(k*DIGITS+i)*8 +: 8] = {4'h3, cand_pass[(k*DIGITS+i)*4 +: 4]};
    end
  end

  always_comb begin
    hit = 1'b0;
    hit_pass = '0;
    for (int k = LANES-1; k >= 0; k--)
      if (res_valid[k] && res_hash[k*128 +: 128] == hash_r) begin
        hit = 1'b1;
        hit_pass = res_pass[k*W +: W];
      end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || abort) begin
      state <= IDLE;
      cand_valid <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      found <= 1'b0;
      pass <= '0;
    end else if (state == IDLE || state == DONE) begin
      if (start) begin
        base <= low;
        high_r <= high;
        hash_r <= hash;
        found <= 1'b0;
        pass <= '0;
        state <= bcd_ok ? RUN : DONE;
        busy <= bcd_ok;
        done <= !bcd_ok;
      end
    end else if (hit) begin
      state <= DONE;
      cand_valid <= '0;
      busy <= 1'b0;
      done <= 1'b1;
      found <= 1'b1;
      pass <= hit_pass;
    end else if (state == RUN) begin
      cand_valid <= lane_ok;
      cand_pass <= lane_val;
      base <= next_base;
      drain_cnt <= '0;
      if (exhausted) state <= DRAIN;
    end else begin
      cand_valid <= '0;
      drain_cnt <= drain_cnt + CW'(1);
      if (drain_cnt == CW'(PIPE_LAT-1)) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

`ifdef MD5_BF_PROGRESS_EN
  logic [32:0] prog_sum;
  always_comb begin
    prog_sum = {1'b0, progress};
    for (int k = 0; k < LANES; k++) prog_sum = prog_sum + 33'(cand_valid[k]);
  end
  always_ff @(posedge clk) begin
    if (!reset_n || abort) progress <= '0;
    else if ((state == IDLE || state == DONE) && start) progress <= '0;
    else if (state == RUN || state == DRAIN) progress <= prog_sum[32] ? '1 : prog_sum[31:0];
  end
`endif
endmodule

// File: tb/tb_md5_bf_sched.sv
// tb_md5_bf_sched: table-driven, hand-sequenced and randomized checks of md5_bf_sched
// against a bench MD5 core model (fixed latency) and an integer range reference.
module tb_md5_bf_sched;
  localparam int LANES = 4;
  localparam int DIGITS = 8;
  localparam int PIPE_LAT = 70;
  localparam int LAT = 64;
  logic clk = 1'b0;
  logic reset_n, start, abort;
  logic [31:0] low, high;
  logic [127:0] hash;
  logic [LANES-1:0] cand_valid, res_valid;
  logic [LANES*64-1:0] cand_msg;
  logic [LANES*32-1:0] cand_pass, res_pass;
  logic [LANES*128-1:0] res_hash;
  logic busy, done, found;
  logic [31:0] pass;
`ifdef MD5_BF_PROGRESS_EN
  logic [31:0] progress;
`endif

  always #5 clk = ~clk;

  md5_bf_sched #(.LANES(LANES), .DIGITS(DIGITS), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .low(low), .high(high), .hash(hash),
    .cand_valid(cand_valid), .cand_msg(cand_msg), .cand_pass(cand_pass),
    .res_valid(res_valid), .res_hash(res_hash), .res_pass(res_pass),
    .busy(busy), .done(done), .found(found), .pass(pass)
`ifdef MD5_BF_PROGRESS_EN
    , .progress(progress)
`endif
  );

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc, issues, bad_issues, last_issue_cyc, first_issue_cyc, lo_i, hi_i;
  bit seen [int];
  bit force_en = 1'b0;
  logic [31:0] kt [64];
  logic [LANES-1:0] ring_v [LAT];
  logic [LANES*128-1:0] ring_h [LAT];
  logic [LANES*32-1:0] ring_p [LAT];

  typedef struct {
    logic [31:0] lo, hi;
    int tgt;
    bit ef;
    logic [31:0] ep;
    int en, el;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic int bcd2int(input logic [31:0] b);
    int v;
    v = 0;
    for (int i = 7; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [63:0] to_msg(input logic [31:0] b);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {4'h3, b[4*i +: 4]};
    return m;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  // Single-block MD5 of an 8-byte message; digest packed as {A,B,C,D}.
  function automatic logic [127:0] md5_model(input logic [63:0] msg);
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f, t;
    int g;
    int sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    for (int j = 0; j < 16; j++) m[j] = '0;
    m[0] = msg[31:0];
    m[1] = msg[63:32];
    m[2] = 32'h80;
    m[14] = 32'd64;
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin f = (b & c) | (~b & d); g = i; end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
      else begin f = c ^ (b | ~d); g = (7 * i) % 16; end
      t = d;
      d = c;
      c = b;
      b = b + rotl(a + f + kt[i] + m[g], sh[(i / 16) * 4 + i % 4]);
      a = t;
    end
    return {a + 32'h67452301, b + 32'hefcdab89, c + 32'h98badcfe, d + 32'h10325476};
  endfunction

  function automatic logic [127:0] hash_of(input int v);
    return md5_model(to_msg(to_bcd(v)));
  endfunction

  // One clock: external cores return results LAT cycles after issue; every issue is scoreboarded.
  task automatic tick();
    int slot, v;
    logic [31:0] p;
    @(posedge clk);
    #1;
    cyc++;
    slot = cyc % LAT;
    if (!force_en) begin
      res_valid = ring_v[slot];
      res_hash = ring_h[slot];
      res_pass = ring_p[slot];
    end
    ring_v[slot] = cand_valid;
    for (int k = 0; k < LANES; k++)
      if (cand_valid[k]) begin
        p = cand_pass[k*32 +: 32];
        ring_h[slot][k*128 +: 128] = md5_model(cand_msg[k*64 +: 64]);
        ring_p[slot][k*32 +: 32] = p;
        v = bcd2int(p);
        if (v < lo_i || v > hi_i || seen.exists(v) || cand_msg[k*64 +: 64] != to_msg(p)) bad_issues++;
        seen[v] = 1'b1;
        issues++;
        last_issue_cyc = cyc;
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
      end
  endtask

  task automatic flush();
    for (int i = 0; i < LAT; i++) ring_v[i] = '0;
    res_valid = '0;
  endtask

  task automatic begin_run(input logic [31:0] lo, input logic [31:0] hi, input int tgt);
    flush();
    lo_i = bcd2int(lo);
    hi_i = bcd2int(hi);
    seen.delete();
    issues = 0;
    bad_issues = 0;
    last_issue_cyc = -1;
    first_issue_cyc = -1;
    low = lo;
    high = hi;
    hash = hash_of(tgt);
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    while (!done && cyc - start_cyc < 3000) tick();
    check({nm, "_timeout"}, longint'(done), 1);
  endtask

  task automatic do_case(input string nm, input logic [31:0] lo, input logic [31:0] hi, input int tgt,
                         input bit ef, input logic [31:0] ep, input int en, input int el);
    logic f0;
    logic [31:0] p0;
    int n0;
    begin_run(lo, hi, tgt);
    f0 = found;
    p0 = pass;
    wait_done(nm);
    check({nm, "_cleared"}, longint'({f0, p0}), 0);
    check({nm, "_found"}, longint'(found), longint'(ef));
    check({nm, "_pass"}, longint'(pass), longint'(ep));
    check({nm, "_bad_issue"}, bad_issues, 0);
    if (en >= 0) check({nm, "_issues"}, issues, en);
    if (el >= 0) check({nm, "_done_lat"}, cyc - start_cyc, el);
    if (issues > 0) check({nm, "_first_issue"}, first_issue_cyc - start_cyc, 2);
    if (!ef && issues > 0) check({nm, "_drain"}, cyc - last_issue_cyc, PIPE_LAT);
`ifdef MD5_BF_PROGRESS_EN
    if (en >= 0) check({nm, "_progress"}, longint'(progress), en);
`endif
    n0 = issues;
    repeat (3) tick();
    check({nm, "_quiet_after_done"}, issues, n0);
    check({nm, "_done_hold"}, longint'({done, busy, found}), longint'({2'b10, ef}));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int i = 0; i < 64; i++) begin
      real x;
      x = $sin(real'(i + 1));
      if (x < 0.0) x = -x;
      kt[i] = 32'(longint'($floor(x * 4294967296.0)));
    end
    for (int i = 0; i < LAT; i++) begin
      ring_v[i] = '0;
      ring_h[i] = '0;
      ring_p[i] = '0;
    end
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    low = '0; high = '0; hash = '0;
    res_valid = '0; res_hash = '0; res_pass = '0;
    repeat (3) tick();
    check("reset_outputs", longint'({cand_valid, busy, done, found, pass}), 0);
`ifdef MD5_BF_PROGRESS_EN
    check("reset_progress", longint'(progress), 0);
`endif
    reset_n = 1'b1;
    tick();

    tbl[0] = '{32'h00001000, 32'h00001999, 1234, 1'b1, 32'h00001234, -1, 125};
    tbl[1] = '{32'h00001000, 32'h00001999, 5555, 1'b0, 32'h0, 1000, 321};
    tbl[2] = '{32'h99999998, 32'h99999999, 7, 1'b0, 32'h0, 2, 72};
    tbl[3] = '{32'h00000010, 32'h00000005, 7, 1'b0, 32'h0, 0, 72};
    tbl[4] = '{32'h00000042, 32'h00000042, 42, 1'b1, 32'h00000042, 1, 67};
    tbl[5] = '{32'h00000000, 32'h00000006, 6, 1'b1, 32'h00000006, 7, 68};
    tbl[6] = '{32'h99999990, 32'h99999999, 99999999, 1'b1, 32'h99999999, 10, 69};
    tbl[7] = '{32'h0000000A, 32'h00000020, 5, 1'b0, 32'h0, 0, 1};
    for (int i = 0; i < 8; i++)
      do_case($sformatf("tbl%0d", i), tbl[i].lo, tbl[i].hi, tbl[i].tgt, tbl[i].ef, tbl[i].ep, tbl[i].en, tbl[i].el);

    do_case("ign_pre", 32'h00000010, 32'h00000005, 7, 1'b0, 32'h0, 0, 72);
    force_en = 1'b1;
    res_valid = 4'b0001;
    res_hash[127:0] = hash_of(7);
    res_pass[31:0] = 32'h00000077;
    tick();
    force_en = 1'b0;
    res_valid = '0;
    check("ignore_res_in_done", longint'({found, pass}), 0);

    begin_run(32'h00000010, 32'h00000005, 7);
    repeat (70) tick();
    check("drain_not_early", longint'(done), 0);
    force_en = 1'b1;
    res_valid = 4'b0001;
    res_hash[127:0] = hash_of(7);
    res_pass[31:0] = 32'h00000077;
    tick();
    force_en = 1'b0;
    res_valid = '0;
    check("match_at_expiry", longint'({done, found, pass}), longint'({2'b11, 32'h00000077}));

    begin_run(32'h00000100, 32'h00000199, 500);
    repeat (5) tick();
    force_en = 1'b1;
    res_valid = 4'b1011;
    res_hash = {hash_of(500), hash_of(501), hash_of(500), hash_of(502)};
    res_pass = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    tick();
    force_en = 1'b0;
    res_valid = '0;
    check("two_lane_pass", longint'({done, found, pass}), longint'({2'b11, 32'h11111111}));
    check("two_lane_quiet", longint'(cand_valid), 0);

    begin_run(32'h00001000, 32'h00001999, 1234);
    repeat (10) tick();
    force_en = 1'b1;
    res_valid = 4'b0100;
    res_hash[256 +: 128] = hash_of(1234);
    res_pass[64 +: 32] = 32'h00001234;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    force_en = 1'b0;
    res_valid = '0;
    check("abort_idle", longint'({cand_valid, busy, done, found, pass}), 0);
`ifdef MD5_BF_PROGRESS_EN
    check("abort_progress", longint'(progress), 0);
`endif
    do_case("restart", 32'h00000000, 32'h00000003, 2, 1'b1, 32'h00000002, 4, 67);

    begin_run(32'h00000000, 32'h00000099, 50);
    repeat (3) tick();
    low = 32'h00000000;
    high = 32'h00000000;
    hash = hash_of(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("start_in_run");
    check("start_in_run_result", longint'({found, pass}), longint'({1'b1, 32'h00000050}));
    n0 = issues;
    check("start_in_run_issues", longint'(n0 >= 51), 1);

    for (int r = 0; r < 12; r++) begin
      int lo, hi, t, n, span, el;
      bit ef;
      lo = (r % 3 == 0) ? 99999999 - int'($urandom_range(0, 30)) : int'($urandom_range(0, 99999000));
      span = int'($urandom_range(0, 44)) - 4;
      hi = lo + span;
      if (hi > 99999999) hi = 99999999;
      if (hi < 0) hi = 0;
      n = (hi >= lo) ? hi - lo + 1 : 0;
      ef = (n > 0) && ($urandom_range(0, 1) == 1);
      t = ef ? lo + int'($urandom_range(0, n - 1)) : (hi < 99999999 ? hi + 1 : lo - 1);
      el = ef ? (t - lo) / LANES + LAT + 3 : (n > 0 ? (n + LANES - 1) / LANES : 1) + PIPE_LAT + 1;
      do_case($sformatf("rnd%0d", r), to_bcd(lo), to_bcd(hi), t, ef, ef ? to_bcd(t) : 32'h0, n, el);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
